// File: rtl/vec_mul_simd_seq.sv
// Multi-cycle SIMD integer multiplier: byte-serial shift-add over 8/16/32-bit lanes.
// Optional per-lane result masking is enabled by defining VMUL_MASK_EN.
module vec_mul_simd_seq #(
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          sew,
    input  logic                signed_a,
    input  logic                signed_b,
    input  logic [DATA_W-1:0]   data_a,
    input  logic [DATA_W-1:0]   data_b,
`ifdef VMUL_MASK_EN
    input  logic [DATA_W/8-1:0] mask_in,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   product_lo,
    output logic [DATA_W-1:0]   product_hi,
    output logic                err
);

    localparam int unsigned NL8   = DATA_W / 8;
    localparam int unsigned NL16  = DATA_W / 16;
    localparam int unsigned NL32  = DATA_W / 32;
    localparam int unsigned ACC_W = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t             state_q, state_nx;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [1:0]         sew_q;
    logic               sa_q, sb_q, err_pend_q;
    logic [NL8-1:0]     mask_q;
    logic [1:0]         cnt_q, last_cnt;
    logic [4:0]         shamt;
    logic [ACC_W-1:0]   acc_q, acc_step, acc_fix;
    logic [DATA_W-1:0]  lo_nx, hi_nx;

    assign shamt = {cnt_q, 3'b000};

    always_comb begin
        case (sew_q)
            2'b00:   last_cnt = 2'd0;
            2'b01:   last_cnt = 2'd1;
            default: last_cnt = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_nx = S_BUSY;
            S_BUSY: if (cnt_q == last_cnt) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One byte of every B lane times the whole A lane, shifted into place.
    always_comb begin
        acc_step = acc_q;
        case (sew_q)
            2'b00: for (int k = 0; k < int'(NL8); k++)
                acc_step[k*16 +: 16] = acc_q[k*16 +: 16]
                    + 16'(a_q[k*8 +: 8]) * 16'(b_q[k*8 +: 8]);
            2'b01: for (int k = 0; k < int'(NL16); k++)
                acc_step[k*32 +: 32] = acc_q[k*32 +: 32]
                    + ((32'(a_q[k*16 +: 16]) * 32'(b_q[k*16 + 32'(shamt) +: 8])) << shamt);
            default: for (int k = 0; k < int'(NL32); k++)
                acc_step[k*64 +: 64] = acc_q[k*64 +: 64]
                    + ((64'(a_q[k*32 +: 32]) * 64'(b_q[k*32 + 32'(shamt) +: 8])) << shamt);
        endcase
    end

    // Turn the unsigned product into the signed/mixed one, modulo 2^(2*SEW).
    always_comb begin
        acc_fix = acc_q;
        case (sew_q)
            2'b00: for (int k = 0; k < int'(NL8); k++)
                acc_fix[k*16 +: 16] = acc_q[k*16 +: 16]
                    - ((sa_q && a_q[k*8+7]) ? {b_q[k*8 +: 8], 8'h00} : 16'h0)
                    - ((sb_q && b_q[k*8+7]) ? {a_q[k*8 +: 8], 8'h00} : 16'h0);
            2'b01: for (int k = 0; k < int'(NL16); k++)
                acc_fix[k*32 +: 32] = acc_q[k*32 +: 32]
                    - ((sa_q && a_q[k*16+15]) ? {b_q[k*16 +: 16], 16'h0} : 32'h0)
                    - ((sb_q && b_q[k*16+15]) ? {a_q[k*16 +: 16], 16'h0} : 32'h0);
            default: for (int k = 0; k < int'(NL32); k++)
                acc_fix[k*64 +: 64] = acc_q[k*64 +: 64]
                    - ((sa_q && a_q[k*32+31]) ? {b_q[k*32 +: 32], 32'h0} : 64'h0)
                    - ((sb_q && b_q[k*32+31]) ? {a_q[k*32 +: 32], 32'h0} : 64'h0);
        endcase
    end

    always_comb begin
        lo_nx = '0;
        hi_nx = '0;
        case (sew_q)
            2'b00: for (int k = 0; k < int'(NL8); k++) if (mask_q[k]) begin
                lo_nx[k*8 +: 8] = acc_fix[k*16 +: 8];
                hi_nx[k*8 +: 8] = acc_fix[k*16 + 8 +: 8];
            end
            2'b01: for (int k = 0; k < int'(NL16); k++) if (mask_q[k]) begin
                lo_nx[k*16 +: 16] = acc_fix[k*32 +: 16];
                hi_nx[k*16 +: 16] = acc_fix[k*32 + 16 +: 16];
            end
            default: for (int k = 0; k < int'(NL32); k++) if (mask_q[k]) begin
                lo_nx[k*32 +: 32] = acc_fix[k*64 +: 32];
                hi_nx[k*32 +: 32] = acc_fix[k*64 + 32 +: 32];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            product_lo <= '0;
            product_hi <= '0;
            err        <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sew_q      <= 2'b00;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            err_pend_q <= 1'b0;
            mask_q     <= '0;
            cnt_q      <= 2'd0;
            acc_q      <= '0;
        end else begin
            in_ready  <= (state_nx == S_IDLE);
            out_valid <= (state_nx == S_DONE);
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q        <= data_a;
                    b_q        <= data_b;
                    sew_q      <= (sew == 2'b11) ? 2'b10 : sew;
                    err_pend_q <= (sew == 2'b11);
                    sa_q       <= signed_a;
                    sb_q       <= signed_b;
`ifdef VMUL_MASK_EN
                    mask_q     <= mask_in;
`else
                    mask_q     <= '1;
`endif
                    cnt_q      <= 2'd0;
                    acc_q      <= '0;
                end
                S_BUSY: begin
                    acc_q <= acc_step;
                    cnt_q <= 2'(cnt_q + 2'd1);
                end
                S_FIX: begin
                    product_lo <= lo_nx;
                    product_hi <= hi_nx;
                    err        <= err_pend_q;
                end
                S_DONE: if (out_ready) err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mul_simd_seq.sv
// Scoreboard bench for vec_mul_simd_seq (DATA_W=32); define VMUL_MASK_EN to exercise lane masking.
module tb_vec_mul_simd_seq;

    localparam int unsigned DATA_W = 32;

    logic              clk, reset, in_valid, in_ready, signed_a, signed_b;
    logic [1:0]        sew;
    logic [DATA_W-1:0] data_a, data_b, product_lo, product_hi;
    logic [3:0]        mask_in;
    logic              out_valid, out_ready, err;

    vec_mul_simd_seq #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sew(sew), .signed_a(signed_a), .signed_b(signed_b),
        .data_a(data_a), .data_b(data_b),
`ifdef VMUL_MASK_EN
        .mask_in(mask_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .product_lo(product_lo), .product_hi(product_hi), .err(err)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          acc_cyc;
        int          nb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0, n_fail = 0, cyc = 0, bp_force = 2;
    logic        prev_valid = 0, held = 0, h_err = 0;
    logic [31:0] h_lo = 0, h_hi = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (bp_force == 0) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: signed/unsigned integer product of each lane taken modulo 2^(2*SEW).
    function automatic void model(input logic [1:0] s, input logic sa, input logic sb,
                                  input logic [31:0] a, input logic [31:0] b, input logic [3:0] m,
                                  output logic [31:0] lo, output logic [31:0] hi);
        int w = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
        logic [63:0] lm = (64'd1 << w) - 64'd1;
        lo = '0;
        hi = '0;
        for (int k = 0; k < 32 / w; k++) begin
            logic [31:0] ua, ub;
            longint av, bv;
            logic [63:0] p;
            ua = 32'((64'(a) >> (k * w)) & lm);
            ub = 32'((64'(b) >> (k * w)) & lm);
            av = longint'(ua);
            bv = longint'(ub);
            if (sa && ua[w-1]) av = av - (longint'(1) << w);
            if (sb && ub[w-1]) bv = bv - (longint'(1) << w);
            p = 64'(av * bv);
            if (m[k]) begin
                lo = lo | (32'(p & lm) << (k * w));
                hi = hi | (32'((p >> w) & lm) << (k * w));
            end
        end
    endfunction

    task automatic issue(input logic [1:0] s, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] m,
                         input logic fixed, input logic [31:0] flo, input logic [31:0] fhi);
        exp_t e;
        int guard = 0;
        if (fixed) begin
            e.lo = flo;
            e.hi = fhi;
        end else begin
            model((s == 2'b11) ? 2'b10 : s, sa, sb, a, b, m, e.lo, e.hi);
        end
        e.err = (s == 2'b11);
        e.nb  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        @(posedge clk); #1;
        in_valid = 1'b1; sew = s; signed_a = sa; signed_b = sb;
        data_a = a; data_b = b; mask_in = m;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_a = $urandom; data_b = $urandom; sew = 2'($urandom);
        signed_a = 1'($urandom); signed_b = 1'($urandom); mask_in = 4'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && in_ready) return;
        end
        n_chk++; n_fail++;
        $display("FAIL idle_timeout: %0d results outstanding, expected 0", exp_q.size());
    endtask

    // Monitor: latency at rise, hold under backpressure, data at handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            held = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 with no request outstanding, expected 0");
                end else begin
                    check("latency", 64'(cyc), 64'(exp_q[0].acc_cyc + exp_q[0].nb + 1));
                end
            end
            if (out_valid) check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_valid && held) begin
                check("hold_lo", 64'(product_lo), 64'(h_lo));
                check("hold_hi", 64'(product_hi), 64'(h_hi));
                check("hold_err", 64'(err), 64'(h_err));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("product_lo", 64'(product_lo), 64'(mon_e.lo));
                check("product_hi", 64'(product_hi), 64'(mon_e.hi));
                check("err", 64'(err), 64'(mon_e.err));
            end
            held  = out_valid && !out_ready;
            h_lo  = product_lo;
            h_hi  = product_hi;
            h_err = err;
            prev_valid = out_valid;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_lo"}, 64'(product_lo), 64'd0);
        check({tag, "_hi"}, 64'(product_hi), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sew = 2'b00; signed_a = 1'b0; signed_b = 1'b0;
        data_a = '0; data_b = '0; mask_in = 4'hF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Directed cases with hand-derived results
        issue(2'b01, 0, 0, 32'h01234567, 32'h89ABCDEF, 4'hF, 1, 32'h7D614629, 32'h009C37D4);
        issue(2'b00, 1, 1, 32'h7F80FF02, 32'h7F02FF03, 4'hF, 1, 32'h01000106, 32'h3FFF0000);
        issue(2'b10, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1, 32'h00000001, 32'h00000000);
        issue(2'b10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1, 32'h00000001, 32'hFFFFFFFE);
        issue(2'b10, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1, 32'h00000001, 32'hFFFFFFFF);
`ifdef VMUL_MASK_EN
        issue(2'b01, 0, 0, 32'h01234567, 32'h89ABCDEF, 4'b0010, 1, 32'h7D610000, 32'h009C0000);
`endif
        wait_idle();

        // Backpressure for 7 cycles on an illegal-sew request
        bp_force = 1;
        out_ready = 1'b0;
        issue(2'b11, 1, 0, 32'h8000_1234, 32'h7FFF_FFFF, 4'hF, 0, 32'h0, 32'h0);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        check("bp_out_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; data_a = $urandom; data_b = $urandom; sew = 2'($urandom);
            @(negedge clk);
            check("bp_valid_held", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        bp_force = 2;
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_err", 64'(err), 64'd0);
        wait_idle();

        // Reset while BUSY at cnt=1 of a 32-bit lane op
        @(posedge clk); #1;
        in_valid = 1'b1; sew = 2'b10; data_a = 32'h1234_5678; data_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end

        // Randomised traffic with random backpressure
        bp_force = 0;
        for (int n = 0; n < 80; n++) begin
            logic [3:0] m;
`ifdef VMUL_MASK_EN
            m = 4'($urandom);
`else
            m = 4'hF;
`endif
            issue(2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, m, 0, 32'h0, 32'h0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk); #1;
        bp_force = 2;
        out_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
